// File: rtl/gem_cluster_packer_if.sv
// Cluster input bus and frame output bus between gem_cluster_packer and its neighbours.
// slave = packer side, master = source/sink side (cluster finder and gem_fiber_out).
interface gem_cluster_packer_if #(
    parameter int DEPTH = 16
);
    logic                     IN_VLD;
    logic [111:0]             IN_CLST;
    logic [55:0]              GEM_DATA;
    logic [7:0]               FRM_SEP;
    logic                     GEM_OVERFLOW;
    logic                     FRM_STRB;
    logic [$clog2(DEPTH):0]   FIFO_OCC;

    modport master (
        output IN_VLD, IN_CLST,
        input  GEM_DATA, FRM_SEP, GEM_OVERFLOW, FRM_STRB, FIFO_OCC
    );

    modport slave (
        input  IN_VLD, IN_CLST,
        output GEM_DATA, FRM_SEP, GEM_OVERFLOW, FRM_STRB, FIFO_OCC
    );
endinterface

// File: rtl/gem_cluster_packer.sv
// Packs up to 8 GEM S-bit clusters per push into 4-slot 56-bit frames, one frame per two TRG_CLK80 cycles.
// Optional GEM_PACK_STATS_EN adds a saturating DROP_CNT output counting dropped clusters.
module gem_cluster_packer #(
    parameter int DEPTH = 16
) (
    input  logic TRG_CLK80,
    input  logic TRG_RST,
    gem_cluster_packer_if.slave bus
`ifdef GEM_PACK_STATS_EN
    ,
    output logic [15:0] DROP_CNT
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic {PH_FIRST, PH_LOAD} phase_t;

    phase_t          ph, ph_next;
    logic [13:0]     mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [OW-1:0]   occ, free_slots;
    logic            ovf, load, vld_eff;
    logic [2:0]      pops;
    logic [3:0]      n_valid, push_n, drop_n;
    logic [13:0]     comp [8];
    logic [55:0]     slot_data, gem_data_q;
    logic [7:0]      sep_q, sep_next;
    logic            ovf_out_q, strb_q;

    always_comb begin
        ph_next = (ph == PH_FIRST) ? PH_LOAD : PH_FIRST;
        load    = (ph == PH_LOAD);
    end

    // Compact valid clusters lowest index first; free space counts this edge's pops.
    always_comb begin
        vld_eff = bus.IN_VLD & ~TRG_RST;
        n_valid = 4'd0;
        for (int k = 0; k < 8; k++) comp[k] = 14'h3FFF;
        for (int k = 0; k < 8; k++) begin
            if (vld_eff && bus.IN_CLST[14*k +: 11] != 11'h7FF) begin
                comp[n_valid[2:0]] = bus.IN_CLST[14*k +: 14];
                n_valid = n_valid + 4'd1;
            end
        end
        pops = 3'd0;
        if (load) pops = (occ >= OW'(4)) ? 3'd4 : occ[2:0];
        free_slots = OW'(DEPTH) - occ + OW'(pops);
        push_n     = (OW'(n_valid) > free_slots) ? free_slots[3:0] : n_valid;
        drop_n     = n_valid - push_n;
    end

    always_comb begin
        slot_data = '1;
        for (int s = 0; s < 4; s++) begin
            if (3'(s) < pops) slot_data[55-14*s -: 14] = mem[rd_ptr + AW'(s)];
        end
        case (sep_q)
            8'hBC:   sep_next = 8'hF7;
            8'hF7:   sep_next = 8'hFB;
            8'hFB:   sep_next = 8'hFD;
            default: sep_next = 8'hBC;
        endcase
    end

    always_ff @(posedge TRG_CLK80) begin
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < push_n) mem[wr_ptr + AW'(i)] <= comp[i];
        end
    end

    // A drop on the load edge is reported in that frame and does not linger in ovf.
    always_ff @(posedge TRG_CLK80) begin
        if (TRG_RST) begin
            ph         <= PH_FIRST;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
            ovf        <= 1'b0;
            gem_data_q <= '1;
            sep_q      <= 8'hBC;
            ovf_out_q  <= 1'b0;
            strb_q     <= 1'b0;
        end else begin
            ph     <= ph_next;
            rd_ptr <= rd_ptr + AW'(pops);
            wr_ptr <= wr_ptr + AW'(push_n);
            occ    <= occ - OW'(pops) + OW'(push_n);
            strb_q <= load;
            if (load) begin
                gem_data_q <= slot_data;
                sep_q      <= sep_next;
                ovf_out_q  <= ovf | (drop_n != 4'd0);
                ovf        <= 1'b0;
            end else begin
                ovf <= ovf | (drop_n != 4'd0);
            end
        end
    end

`ifdef GEM_PACK_STATS_EN
    logic [15:0] drop_cnt_q;
    logic [16:0] drop_sum;

    assign drop_sum = {1'b0, drop_cnt_q} + 17'(drop_n);

    always_ff @(posedge TRG_CLK80) begin
        if (TRG_RST) drop_cnt_q <= '0;
        else         drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign DROP_CNT = drop_cnt_q;
`endif

    assign bus.GEM_DATA     = gem_data_q;
    assign bus.FRM_SEP      = sep_q;
    assign bus.GEM_OVERFLOW = ovf_out_q;
    assign bus.FRM_STRB     = strb_q;
    assign bus.FIFO_OCC     = occ;
endmodule

// File: tb/tb_gem_cluster_packer.sv
// Self-checking bench for gem_cluster_packer: vector table, directed corner sequences, and
// randomized traffic compared against a queue-based frame model.
module tb_gem_cluster_packer;
    localparam int DEPTH = 16;
    localparam logic [111:0] IDLE = {8{14'h07FF}};
    localparam logic [55:0]  ONES = '1;

    logic TRG_CLK80 = 1'b0;
    logic TRG_RST;

    gem_cluster_packer_if #(.DEPTH(DEPTH)) bus ();
`ifdef GEM_PACK_STATS_EN
    logic [15:0] DROP_CNT;
`endif

    gem_cluster_packer #(.DEPTH(DEPTH)) dut (
        .TRG_CLK80 (TRG_CLK80),
        .TRG_RST   (TRG_RST),
        .bus       (bus)
`ifdef GEM_PACK_STATS_EN
        ,
        .DROP_CNT  (DROP_CNT)
`endif
    );

    always #5 TRG_CLK80 = ~TRG_CLK80;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a queue of clusters plus frame bookkeeping
    logic [13:0] m_q [$];
    bit          m_ph;
    bit          m_ovf;
    bit          m_gem_ovf;
    bit          m_strb;
    logic [55:0] m_data;
    int          m_sep_idx;
    int          m_drop_cnt;

    typedef struct {
        logic         rst;
        logic         vld;
        logic [111:0] clst;
        logic [55:0]  exp_data;
        logic [7:0]   exp_sep;
        logic         exp_ovf;
        logic         exp_strb;
        logic [4:0]   exp_occ;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [7:0] sepOf(input int idx);
        case (idx % 4)
            0:       return 8'hBC;
            1:       return 8'hF7;
            2:       return 8'hFB;
            default: return 8'hFD;
        endcase
    endfunction

    function automatic logic [111:0] makeClst(input int count, input int base);
        logic [111:0] c;
        c = IDLE;
        for (int k = 0; k < count; k++) c[14*k +: 14] = 14'(base + k);
        return c;
    endfunction

    task automatic modelStep(input logic rst, input logic vld, input logic [111:0] clst);
        logic [13:0] popped [$];
        logic [13:0] c;
        bit          load;
        int          n;
        int          drops;
        if (rst) begin
            m_q.delete();
            m_ph = 0; m_ovf = 0; m_gem_ovf = 0; m_strb = 0;
            m_data = ONES; m_sep_idx = 0; m_drop_cnt = 0;
        end else begin
            load = m_ph;
            if (load) begin
                n = (m_q.size() < 4) ? m_q.size() : 4;
                repeat (n) popped.push_back(m_q.pop_front());
            end
            drops = 0;
            if (vld) begin
                for (int k = 0; k < 8; k++) begin
                    c = clst[14*k +: 14];
                    if (c[10:0] != 11'h7FF) begin
                        if (m_q.size() < DEPTH) m_q.push_back(c);
                        else drops++;
                    end
                end
            end
            m_drop_cnt = (m_drop_cnt + drops > 65535) ? 65535 : m_drop_cnt + drops;
            if (load) begin
                m_data = ONES;
                for (int s = 0; s < popped.size(); s++) m_data[55-14*s -: 14] = popped[s];
                m_gem_ovf = m_ovf || (drops > 0);
                m_ovf = 0;
                m_sep_idx++;
            end else begin
                m_ovf = m_ovf || (drops > 0);
            end
            m_strb = load;
            m_ph = !m_ph;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic vld, input logic [111:0] clst);
        TRG_RST    = rst;
        bus.IN_VLD = vld;
        bus.IN_CLST = clst;
        @(posedge TRG_CLK80);
        modelStep(rst, vld, clst);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic [55:0] d, input logic o, input logic [4:0] occ);
        checkOutput({tag, ".data"}, 64'(bus.GEM_DATA), 64'(d));
        checkOutput({tag, ".ovf"}, 64'(bus.GEM_OVERFLOW), 64'(o));
        checkOutput({tag, ".occ"}, 64'(bus.FIFO_OCC), 64'(occ));
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".data"}, 64'(bus.GEM_DATA), 64'(m_data));
        checkOutput({tag, ".sep"}, 64'(bus.FRM_SEP), 64'(sepOf(m_sep_idx)));
        checkOutput({tag, ".ovf"}, 64'(bus.GEM_OVERFLOW), 64'(m_gem_ovf));
        checkOutput({tag, ".strb"}, 64'(bus.FRM_STRB), 64'(m_strb));
        checkOutput({tag, ".occ"}, 64'(bus.FIFO_OCC), 64'(m_q.size()));
`ifdef GEM_PACK_STATS_EN
        checkOutput({tag, ".dropcnt"}, 64'(DROP_CNT), 64'(m_drop_cnt));
`endif
    endtask

    initial begin
        logic [111:0] rnd_clst;
        logic         rnd_vld;
        logic         rnd_rst;
        int           vld_pct;

        TRG_RST = 1'b1;
        bus.IN_VLD = 1'b0;
        bus.IN_CLST = IDLE;

        // Reset, idle K-code rotation, then a three-cluster push
        vecs[0]  = '{1'b1, 1'b0, IDLE, ONES, 8'hBC, 1'b0, 1'b0, 5'd0};
        vecs[1]  = '{1'b0, 1'b0, IDLE, ONES, 8'hBC, 1'b0, 1'b0, 5'd0};
        vecs[2]  = '{1'b0, 1'b0, IDLE, ONES, 8'hF7, 1'b0, 1'b1, 5'd0};
        vecs[3]  = '{1'b0, 1'b0, IDLE, ONES, 8'hF7, 1'b0, 1'b0, 5'd0};
        vecs[4]  = '{1'b0, 1'b0, IDLE, ONES, 8'hFB, 1'b0, 1'b1, 5'd0};
        vecs[5]  = '{1'b0, 1'b1, {{5{14'h07FF}}, 14'h1033, 14'h0822, 14'h0011},
                     ONES, 8'hFB, 1'b0, 1'b0, 5'd3};
        vecs[6]  = '{1'b0, 1'b0, IDLE, {14'h0011, 14'h0822, 14'h1033, 14'h3FFF}, 8'hFD, 1'b0, 1'b1, 5'd0};
        vecs[7]  = '{1'b0, 1'b0, IDLE, {14'h0011, 14'h0822, 14'h1033, 14'h3FFF}, 8'hFD, 1'b0, 1'b0, 5'd0};
        vecs[8]  = '{1'b0, 1'b0, IDLE, ONES, 8'hBC, 1'b0, 1'b1, 5'd0};
        vecs[9]  = '{1'b0, 1'b0, IDLE, ONES, 8'hBC, 1'b0, 1'b0, 5'd0};
        vecs[10] = '{1'b0, 1'b0, IDLE, ONES, 8'hF7, 1'b0, 1'b1, 5'd0};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].clst);
            checkState($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ovf, vecs[i].exp_occ);
            checkOutput($sformatf("vec%0d.sep", i), 64'(bus.FRM_SEP), 64'(vecs[i].exp_sep));
            checkOutput($sformatf("vec%0d.strb", i), 64'(bus.FRM_STRB), 64'(vecs[i].exp_strb));
        end

        // Eight-cluster burst drains over two frames
        applyStimulus(1'b0, 1'b1, makeClst(8, 1));
        checkState("burst.push", ONES, 1'b0, 5'd8);
        applyStimulus(1'b0, 1'b0, IDLE);
        checkState("burst.f0", {14'h0001, 14'h0002, 14'h0003, 14'h0004}, 1'b0, 5'd4);
        applyStimulus(1'b0, 1'b0, IDLE);
        applyStimulus(1'b0, 1'b0, IDLE);
        checkState("burst.f1", {14'h0005, 14'h0006, 14'h0007, 14'h0008}, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, IDLE);
        applyStimulus(1'b0, 1'b0, IDLE);
        checkState("burst.f2", ONES, 1'b0, 5'd0);

        // Push landing on the load edge
        applyStimulus(1'b0, 1'b1, makeClst(4, 'h20));
        checkState("ldpush.pre", ONES, 1'b0, 5'd4);
        applyStimulus(1'b0, 1'b1, makeClst(2, 'h30));
        checkState("ldpush.f0", {14'h0020, 14'h0021, 14'h0022, 14'h0023}, 1'b0, 5'd2);
        applyStimulus(1'b0, 1'b0, IDLE);
        applyStimulus(1'b0, 1'b0, IDLE);
        checkState("ldpush.f1", {14'h0030, 14'h0031, 14'h3FFF, 14'h3FFF}, 1'b0, 5'd0);

        // Overflow: third push of 8 only finds 4 free slots
        applyStimulus(1'b0, 1'b1, makeClst(8, 'h40));
        checkState("ovf.p0", {14'h0030, 14'h0031, 14'h3FFF, 14'h3FFF}, 1'b0, 5'd8);
        applyStimulus(1'b0, 1'b1, makeClst(8, 'h50));
        checkState("ovf.p1", {14'h0040, 14'h0041, 14'h0042, 14'h0043}, 1'b0, 5'd12);
        applyStimulus(1'b0, 1'b1, makeClst(8, 'h60));
        checkState("ovf.p2", {14'h0040, 14'h0041, 14'h0042, 14'h0043}, 1'b0, 5'd16);
`ifdef GEM_PACK_STATS_EN
        checkOutput("ovf.dropcnt", 64'(DROP_CNT), 64'd4);
`endif
        applyStimulus(1'b0, 1'b0, IDLE);
        checkState("ovf.f0", {14'h0044, 14'h0045, 14'h0046, 14'h0047}, 1'b1, 5'd12);
        applyStimulus(1'b0, 1'b0, IDLE);
        applyStimulus(1'b0, 1'b0, IDLE);
        checkState("ovf.f1", {14'h0050, 14'h0051, 14'h0052, 14'h0053}, 1'b0, 5'd8);

        // Drop on the load edge, then sticky drop, then reset mid-operation
        applyStimulus(1'b0, 1'b1, makeClst(8, 'h70));
        checkState("rst.p0", {14'h0050, 14'h0051, 14'h0052, 14'h0053}, 1'b0, 5'd16);
        applyStimulus(1'b0, 1'b1, makeClst(8, 'h78));
        checkState("rst.ldrop", {14'h0054, 14'h0055, 14'h0056, 14'h0057}, 1'b1, 5'd16);
        applyStimulus(1'b0, 1'b1, makeClst(8, 'h80));
        checkState("rst.p2", {14'h0054, 14'h0055, 14'h0056, 14'h0057}, 1'b1, 5'd16);
        applyStimulus(1'b1, 1'b1, makeClst(8, 'h90));
        checkState("rst.hold", ONES, 1'b0, 5'd0);
        checkOutput("rst.sep", 64'(bus.FRM_SEP), 64'(8'hBC));
        checkOutput("rst.strb", 64'(bus.FRM_STRB), 64'd0);
`ifdef GEM_PACK_STATS_EN
        checkOutput("rst.dropcnt", 64'(DROP_CNT), 64'd0);
`endif
        applyStimulus(1'b0, 1'b0, IDLE);
        checkOutput("rst.ph0.strb", 64'(bus.FRM_STRB), 64'd0);
        applyStimulus(1'b0, 1'b0, IDLE);
        checkOutput("rst.ph1.strb", 64'(bus.FRM_STRB), 64'd1);
        checkOutput("rst.ph1.sep", 64'(bus.FRM_SEP), 64'(8'hF7));
        checkState("rst.ph1", ONES, 1'b0, 5'd0);

        // Randomized traffic against the model; heavy load first, then light
        for (int cyc = 0; cyc < 800; cyc++) begin
            vld_pct = (cyc < 400) ? 75 : 30;
            rnd_rst = ($urandom_range(0, 199) == 0);
            rnd_vld = ($urandom_range(0, 99) < vld_pct);
            rnd_clst = IDLE;
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 99) < 55)
                    rnd_clst[14*k +: 14] = {3'($urandom_range(0, 7)), 11'($urandom_range(0, 2046))};
            end
            applyStimulus(rnd_rst, rnd_vld, rnd_clst);
            checkModel($sformatf("rand%0d", cyc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
